apb_reg_arbiter: RTL and testbench
==================================

Name: apb_reg_arbiter

Overview:
- Multi-requester APB master that shares one register-bus target (e.g. a generated *Regs block) among NUM_REQ clients.
- Per-client transaction interface: round-robin grant, APB SETUP/ACCESS sequencing, wait-state handling and timeout.
- Returns read data and error to the granted client.
- Sits between firmware/test agents or sequencers and the block register slave.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- TIMEOUT_CYCLES, 16, max ACCESS cycles without pready before forced error; 0 disables timeout.
- BAD_DATA, 32'hBADD_C0DE, read data returned on error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-client request valid.
- req_ready  out  NUM_REQ  per-client accept; one-hot or zero.
- req_addr  in  NUM_REQ*32  per-client byte address; slice i = [32*i+:32].
- req_write  in  NUM_REQ  1=write, 0=read.
- req_wdata  in  NUM_REQ*32  per-client write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning client.
- rsp_rdata  out  32  read data, shared; valid with rsp_valid.
- rsp_err  out  1  error flag, shared; valid with rsp_valid.
- paddr  out  32  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, rr_ptr=0, timeout counter=0. Assertion mid-transaction drops psel/penable immediately, asynchronously. The in-flight transaction is lost and produces no rsp_valid.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward with wrap.
  - Same cycle: req_ready[g]=1 (combinational from req_valid and state).
  - Latch addr, write, wdata and g.
  - Set rr_ptr=(g+1) mod NUM_REQ.
  - Go to SETUP, or to RESP if addr[1:0]!=0.
  - No req_valid: stay in IDLE, rr_ptr unchanged.
- Misaligned address: no APB cycle. RESP with rsp_err=1, rsp_rdata=BAD_DATA.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata driven from latched values. Go to ACCESS after 1 cycle.
- ACCESS:
  - psel=1, penable=1; address, control and data held stable.
  - On pready=1: capture prdata (reads only; writes capture 0) and pslverr, then go to RESP.
  - Timeout counter increments each ACCESS cycle without pready.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 while pready=0, go to RESP with err=1, rdata=BAD_DATA. psel/penable are deasserted next cycle.
  - pready in the same cycle as the timeout limit wins; normal completion.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle; rsp_rdata/rsp_err registered and stable that cycle.
  - psel=0; counter cleared; go to IDLE.
  - rsp_rdata/rsp_err return to 0 outside RESP.
- Latency: grant at cycle T, SETUP T+1, ACCESS T+2, rsp_valid at T+3+W, where W = wait cycles.
- Throughput: minimum 4 cycles per transaction; no back-to-back overlap. req_ready is never asserted outside IDLE.
- Requester obligation: hold req_valid and payload stable until req_ready. Dropping req_valid before grant is permitted; that request is simply not granted.
- Fairness: with all clients continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0; no client waits more than NUM_REQ-1 transactions.
- NUM_REQ=1: rr_ptr is constant 0.

Test Plan:
- Client0 write 0x0 data 0x55, pready tied 1 → psel rises T+1, penable T+2, pwdata=0x55; rsp_valid[0] at T+3, err=0.
- Client1 read 0x8, pready after 3 wait cycles, prdata=0xA → rsp_valid[1] at T+6, rdata=0xA, paddr/pwrite stable across all ACCESS cycles.
- Both clients requesting continuously for 4 transactions → grant order 0,1,0,1; only one req_ready bit high at a time.
- Read 0x4 with pslverr=1 on the pready cycle → rsp_err=1, rsp_rdata=prdata as returned. Read 0x2 (misaligned) → no psel; rsp_err=1, rdata=0xBADDC0DE at T+1.
- pready held 0, TIMEOUT_CYCLES=16 → 16 ACCESS cycles, then rsp_err=1, rdata=0xBADDC0DE, psel low next cycle.
- rst asserted during ACCESS → psel/penable 0 immediately, no rsp_valid; the next request after release is granted from rr_ptr=0.

Source files
------------

// File: rtl/apb_reg_arbiter.sv
// apb_reg_arbiter
//   Shares one APB register target among NUM_REQ clients. Requests are granted
//   round-robin from IDLE, then run as a single APB SETUP/ACCESS transfer with
//   wait-state support and an optional ACCESS timeout. The result is returned
//   to the granting client as a one-cycle rsp_valid pulse with shared
//   rsp_rdata/rsp_err. Misaligned addresses are answered with an error and no
//   bus cycle.
//
// Parameters
//   NUM_REQ         number of requesters (1..8)
//   TIMEOUT_CYCLES  ACCESS cycles without pready before a forced error (0 = off)
//   BAD_DATA        read data returned with an error response
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_valid       per-client request valid
//   req_ready       per-client accept, one-hot or zero, only in IDLE
//   req_addr        per-client byte address, slice i = [32*i +: 32]
//   req_write       per-client direction, 1 = write
//   req_wdata       per-client write data, slice i = [32*i +: 32]
//   rsp_valid       one-cycle completion pulse to the owning client
//   rsp_rdata       shared read data, valid with rsp_valid, 0 otherwise
//   rsp_err         shared error flag, valid with rsp_valid, 0 otherwise
//   paddr, psel, penable, pwrite, pwdata    APB request side
//   prdata, pready, pslverr                 APB completion side
module apb_reg_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] BAD_DATA       = 32'hBADD_C0DE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [31:0]            paddr,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [31:0]            pwdata,
    input  logic [31:0]            prdata,
    input  logic                   pready,
    input  logic                   pslverr
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Counter value at which a still-stalled ACCESS is abandoned.
    localparam logic [31:0] TO_LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             write_q;
    logic [31:0]      to_cnt;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             gnt_found;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] rr_next;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             sel_write;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    // The payload mux is folded into the same pass.
    always_comb begin
        int unsigned k;
        k         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_next   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = (32'(rr_ptr) + i) % NUM_REQ;
            if (!gnt_found && req_valid[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(k);
                rr_next   = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
                sel_addr  = req_addr[32*k +: 32];
                sel_wdata = req_wdata[32*k +: 32];
                sel_write = req_write[k];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == ST_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    // psel/penable decode straight from the state register so that an
    // asynchronous reset drops them without waiting for a clock edge.
    assign psel      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign penable   = (state == ST_ACCESS);
    assign paddr     = addr_q;
    assign pwrite    = write_q;
    assign pwdata    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            to_cnt  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_found) begin
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        write_q <= sel_write;
                        owner_q <= gnt_idx;
                        rr_ptr  <= rr_next;
                        if (sel_addr[1:0] != 2'b00) begin
                            // Misaligned: answer directly without touching the bus.
                            rdata_q <= BAD_DATA;
                            err_q   <= 1'b1;
                            state   <= ST_RESP;
                        end else begin
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    to_cnt <= '0;
                    state  <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready wins over a timeout landing in the same cycle.
                    if (pready) begin
                        rdata_q <= write_q ? '0 : prdata;
                        err_q   <= pslverr;
                        to_cnt  <= '0;
                        state   <= ST_RESP;
                    end else if (TIMEOUT_CYCLES != 0 && to_cnt == TO_LIMIT) begin
                        rdata_q <= BAD_DATA;
                        err_q   <= 1'b1;
                        to_cnt  <= '0;
                        state   <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                ST_RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    to_cnt  <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reg_arbiter.sv
// tb_apb_reg_arbiter
//   Scoreboard bench for apb_reg_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=16).
//   Expected APB transfers and responses are queued when a grant is seen and
//   checked by monitors when the DUT produces them. An APB slave process
//   answers with a configurable number of wait states, data and error.
module tb_apb_reg_arbiter;

    localparam int          N   = 2;
    localparam logic [31:0] BAD = 32'hBADD_C0DE;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_addr;
    logic [N-1:0]      req_write;
    logic [N*32-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    apb_reg_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16),
        .BAD_DATA       (BAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    typedef struct {
        int          client;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          cyc;
        int          n_acc;
    } apb_t;

    rsp_t rsp_q[$];
    apb_t apb_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          tb_rr    = 0;
    int          slv_wait = 0;
    logic        slv_hang = 1'b0;
    logic        slv_err  = 1'b0;
    logic [31:0] slv_rdata = '0;
    logic [31:0] cl_addr  [N];
    logic [31:0] cl_wdata [N];
    logic        cl_write [N];
    logic        in_acc = 1'b0;
    apb_t        cur_apb;
    int          acc_n = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (ptr + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_req(input int c, input logic [31:0] a, input logic w, input logic [31:0] d);
        cl_addr[c]          = a;
        cl_write[c]         = w;
        cl_wdata[c]         = d;
        req_addr[32*c +: 32]  = a;
        req_wdata[32*c +: 32] = d;
        req_write[c]        = w;
        req_valid[c]        = 1'b1;
    endtask

    // Called right after a negedge. Returns the client index the DUT granted
    // (-1 if none within the budget) and queues the expected outcome.
    task automatic wait_grant(output int g);
        int n;
        int eg;
        int t;
        apb_t a;
        rsp_t r;
        n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        g = -1;
        if (req_ready == '0) begin
            check_eq("grant_seen", 32'(req_ready != '0), 32'd1);
            return;
        end
        for (int i = N - 1; i >= 0; i--) if (req_ready[i]) g = i;
        eg = pick(req_valid, tb_rr);
        check_eq("grant", 32'(req_ready), 32'd1 << eg);
        t = cyc;
        r.client = eg;
        if (cl_addr[eg][1:0] != 2'b00) begin
            r.rdata = BAD;
            r.err   = 1'b1;
            r.cyc   = t + 1;
        end else begin
            a.addr  = cl_addr[eg];
            a.write = cl_write[eg];
            a.wdata = cl_wdata[eg];
            a.cyc   = t + 1;
            a.n_acc = slv_hang ? 16 : slv_wait + 1;
            apb_q.push_back(a);
            r.rdata = slv_hang ? BAD : (cl_write[eg] ? 32'h0 : slv_rdata);
            r.err   = slv_hang ? 1'b1 : slv_err;
            r.cyc   = slv_hang ? t + 18 : t + 3 + slv_wait;
        end
        rsp_q.push_back(r);
        tb_rr = (eg + 1) % N;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (rsp_q.size() != 0) begin
            check_eq("rsp_pending", rsp_q.size(), 0);
            rsp_q.delete();
        end
    endtask

    task automatic run_one();
        int g;
        wait_grant(g);
        if (g >= 0) begin
            @(negedge clk);
            req_valid[g] = 1'b0;
        end
        wait_done();
    endtask

    // APB slave: pready after slv_wait wait states unless slv_hang.
    initial begin : apb_slave
        int acc;
        acc = 0;
        pready = 1'b0;
        prdata = '0;
        pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                pready = !slv_hang && (acc == slv_wait);
                acc++;
            end else begin
                pready = 1'b0;
                acc = 0;
            end
            prdata  = slv_rdata;
            pslverr = pready && slv_err;
        end
    end

    initial begin : rsp_mon
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    check_eq("rsp_who", 32'(rsp_valid), 32'd1 << e.client);
                    check_eq("rsp_rdata", rsp_rdata, e.rdata);
                    check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
                    check_eq("rsp_cycle", cyc, e.cyc);
                end
            end else begin
                check_eq("rsp_rdata_idle", rsp_rdata, 32'd0);
                check_eq("rsp_err_idle", 32'(rsp_err), 32'd0);
            end
            check_eq("rdy_onehot", 32'($onehot0(req_ready)), 32'd1);
            if (psel) check_eq("rdy_busy", 32'(req_ready), 32'd0);
        end
    end

    initial begin : apb_mon
        forever begin
            @(negedge clk);
            #2;
            if (psel && !penable) begin
                if (apb_q.size() == 0) begin
                    check_eq("apb_unexpected", 32'(psel), 32'd0);
                end else begin
                    cur_apb = apb_q.pop_front();
                    check_eq("setup_cycle", cyc, cur_apb.cyc);
                    check_eq("setup_paddr", paddr, cur_apb.addr);
                    check_eq("setup_pwrite", 32'(pwrite), 32'(cur_apb.write));
                    if (cur_apb.write) check_eq("setup_pwdata", pwdata, cur_apb.wdata);
                    in_acc = 1'b1;
                    acc_n  = 0;
                end
            end else if (psel && penable && in_acc) begin
                acc_n++;
                if (acc_n == 1) check_eq("access_cycle", cyc, cur_apb.cyc + 1);
                check_eq("access_paddr", paddr, cur_apb.addr);
                check_eq("access_pwrite", 32'(pwrite), 32'(cur_apb.write));
            end else if (!psel && in_acc) begin
                check_eq("access_count", acc_n, cur_apb.n_acc);
                in_acc = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin : main
        int g;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_psel", 32'(psel), 32'd0);
        check_eq("rst_penable", 32'(penable), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_paddr", paddr, 32'd0);
        check_eq("rst_pwdata", pwdata, 32'd0);
        check_eq("rst_pwrite", 32'(pwrite), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Write, zero wait states; write response carries 0 data.
        slv_wait = 0;
        slv_rdata = 32'hFFFF_0000;
        @(negedge clk);
        set_req(0, 32'h0, 1'b1, 32'h55);
        run_one();

        // Read with three wait states.
        slv_wait = 3;
        slv_rdata = 32'h0000_000A;
        @(negedge clk);
        set_req(1, 32'h8, 1'b0, 32'h0);
        run_one();

        // Both clients requesting continuously: grants alternate.
        slv_wait = 1;
        @(negedge clk);
        set_req(0, 32'h100, 1'b0, 32'h0);
        set_req(1, 32'h104, 1'b1, 32'h1111);
        for (int i = 0; i < 4; i++) begin
            slv_rdata = 32'h1000 + i;
            wait_grant(g);
            check_eq("rr_order", g, i % 2);
            if (g >= 0) begin
                @(negedge clk);
                req_valid[g] = 1'b0;
            end
            wait_done();
            if (i < 3 && g >= 0) set_req(g, cl_addr[g], cl_write[g], cl_wdata[g]);
            else req_valid = '0;
        end

        // Slave error returned with the data the slave drove.
        slv_wait = 0;
        slv_err = 1'b1;
        slv_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        set_req(0, 32'h4, 1'b0, 32'h0);
        run_one();
        slv_err = 1'b0;

        // Misaligned read and write: no bus cycle, immediate error.
        @(negedge clk);
        set_req(1, 32'h2, 1'b0, 32'h0);
        run_one();
        @(negedge clk);
        set_req(0, 32'h7, 1'b1, 32'h77);
        run_one();

        // Slave never ready: timeout after 16 ACCESS cycles.
        slv_hang = 1'b1;
        @(negedge clk);
        set_req(1, 32'hC, 1'b0, 32'h0);
        run_one();

        // Reset during ACCESS: bus drops at once, transaction discarded.
        @(negedge clk);
        set_req(0, 32'h10, 1'b0, 32'h0);
        wait_grant(g);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        #3;
        check_eq("pre_rst_penable", 32'(penable), 32'd1);
        rst = 1'b1;
        in_acc = 1'b0;
        rsp_q.delete();
        apb_q.delete();
        tb_rr = 0;
        #1;
        check_eq("rst_async_psel", 32'(psel), 32'd0);
        check_eq("rst_async_penable", 32'(penable), 32'd0);
        check_eq("rst_async_rsp", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        slv_hang = 1'b0;
        repeat (3) @(negedge clk);

        // After reset the pointer restarts at client 0.
        slv_wait = 2;
        slv_rdata = 32'h0000_5A5A;
        set_req(1, 32'h20, 1'b0, 32'h0);
        set_req(0, 32'h24, 1'b1, 32'hCAFE);
        wait_grant(g);
        check_eq("post_rst_grant", g, 0);
        if (g >= 0) begin
            @(negedge clk);
            req_valid[g] = 1'b0;
        end
        wait_done();
        run_one();
        req_valid = '0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
